seg_scan_capture: RTL



---
 rtl/seg_scan_capture.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - decode a multiplexed 4-digit seven-segment scan bus into a confirmed 16-bit word
module seg_scan_capture #(
    parameter int SETTLE  = 4,
    parameter int CONFIRM = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  pos,
    input  logic [7:0]  seg,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        locked
);
    localparam int CW = $clog2(SETTLE + 2);
    localparam int MW = $clog2(CONFIRM + 1);
    localparam logic [CW-1:0] CNT_FIRE  = CW'(SETTLE);
    localparam logic [CW-1:0] CNT_MAX   = CW'(SETTLE + 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(CONFIRM);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK} state_t;

    state_t      state_q, state_d;
    logic [3:0]  pos_s1_q, pos_s2_q;
    logic [6:0]  seg_s1_q, seg_s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  slot_q [4];
    logic [3:0]  mask_q, mask_d, base_mask;
    logic [15:0] cand_q, data_out_q, word;
    logic [MW-1:0] match_q, match_d;
    logic        data_valid_q, frame_err_q, locked_q;

    logic        changed, sel_valid, fire, dig_valid, reslot, write_en, err;
    logic        do_check, frame_open, confirmed, new_word;
    logic [1:0]  sel_idx;
    logic [3:0]  sel_bit, dig_code;
    logic        unused_dp;

    assign unused_dp = seg[7];

    always_comb begin
        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        case (pos_s2_q)
            4'b0111: sel_idx = 2'd3;
            4'b1011: sel_idx = 2'd2;
            4'b1101: sel_idx = 2'd1;
            4'b1110: sel_idx = 2'd0;
            default: sel_valid = 1'b0;
        endcase
    end

    assign sel_bit = 4'b0001 << sel_idx;

    always_comb begin
        dig_valid = 1'b1;
        dig_code  = 4'd0;
        case (~seg_s2_q)
            7'h3F:   dig_code = 4'd0;
            7'h06:   dig_code = 4'd1;
            7'h5B:   dig_code = 4'd2;
            7'h4F:   dig_code = 4'd3;
            7'h66:   dig_code = 4'd4;
            7'h6D:   dig_code = 4'd5;
            7'h7D:   dig_code = 4'd6;
            7'h07:   dig_code = 4'd7;
            7'h7F:   dig_code = 4'd8;
            7'h6F:   dig_code = 4'd9;
            7'h40:   dig_code = 4'd10;
            default: dig_valid = 1'b0;
        endcase
    end

    // s1 vs s2 exposes a change one cycle before s2 takes it, so a dwell must last SETTLE+2 pin cycles
    assign changed = (pos_s1_q != pos_s2_q) || (seg_s1_q != seg_s2_q);
    assign fire    = sel_valid && !changed && (cnt_q == CNT_FIRE);

    always_comb begin
        cnt_d = cnt_q;
        if (changed || !sel_valid) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign base_mask = frame_open ? mask_q : 4'h0;
    assign reslot    = |(base_mask & sel_bit);
    assign write_en  = fire && dig_valid;
    assign err       = fire && (!dig_valid || reslot);

    always_comb begin
        mask_d = base_mask;
        if (err) begin
            mask_d = 4'h0;
        end
        if (write_en) begin
            mask_d = mask_d | sel_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (err) begin
            state_d = write_en ? S_FILL : S_IDLE;
        end else if (write_en) begin
            state_d = (mask_d == 4'hF) ? S_CHECK : S_FILL;
        end else if (state_q == S_CHECK) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        do_check   = 1'b0;
        frame_open = 1'b1;
        case (state_q)
            S_CHECK: begin
                do_check   = 1'b1;
                frame_open = 1'b0;
            end
            default: ;
        endcase
    end

    assign word     = {slot_q[3], slot_q[2], slot_q[1], slot_q[0]};
    assign new_word = (word != data_out_q);

    always_comb begin
        if (word == cand_q) begin
            match_d = (match_q == MATCH_MAX) ? match_q : match_q + 1'b1;
        end else begin
            match_d = MW'(1);
        end
    end

    assign confirmed = (match_d == MATCH_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_s1_q     <= '0;
            pos_s2_q     <= '0;
            seg_s1_q     <= '0;
            seg_s2_q     <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            cand_q       <= '0;
            match_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            locked_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            pos_s1_q     <= pos;
            pos_s2_q     <= pos_s1_q;
            seg_s1_q     <= seg[6:0];
            seg_s2_q     <= seg_s1_q;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            frame_err_q  <= err;
            data_valid_q <= 1'b0;
            if (write_en) begin
                slot_q[sel_idx] <= dig_code;
            end
            if (do_check) begin
                cand_q  <= word;
                match_q <= match_d;
                if (confirmed && new_word) begin
                    data_out_q   <= word;
                    data_valid_q <= 1'b1;
                end
                if (confirmed && !new_word) begin
                    locked_q <= 1'b1;
                end else if (new_word) begin
                    locked_q <= 1'b0;
                end
            end
            // a discarded frame breaks the run of consecutive identical frames
            if (err) begin
                match_q  <= '0;
                locked_q <= 1'b0;
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign locked     = locked_q;

endmodule
